// File: rtl/bus_cycle_initiator.sv
// bus_cycle_initiator
// Initiator end of an 8088-style bus. Each accepted host command becomes one
// T1-T2-T3-T4 bus cycle on ALE/RD/WR/IOM/ADDR/DATA, followed by a one-cycle
// completion pulse on rsp_valid.
//
// Build option: define BUS_READY_EN to add the READY input and TW wait
// states. A wait that hits MAX_WAIT aborts the cycle with rsp_err. With the
// macro undefined there is no READY port, T3 always goes to T4 and rsp_err
// is tied low.
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so the host must
// hold a command stable until that edge. rsp_valid is a single-cycle pulse
// with no back-pressure.
//
// Debug taps: dbg_state (FSM encoding below), dbg_data_oe (DATA driver
// enable) and dbg_wait (wait-state counter, zero when BUS_READY_EN is
// undefined).
module bus_cycle_initiator #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15,
    localparam int WAIT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_io,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
`ifdef BUS_READY_EN
    input  logic              READY,
`endif
    output logic [2:0]        dbg_state,
    output logic              dbg_data_oe,
    output logic [WAIT_W-1:0] dbg_wait
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              iom_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              strobe;
    logic              data_oe;

`ifdef BUS_READY_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
`endif

    // Cycle sequencer: latch the command on accept, step through the bus phases, capture read data
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            iom_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BUS_READY_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        iom_q   <= cmd_io;
                        write_q <= cmd_write;
                        wdata_q <= cmd_wdata;
`ifdef BUS_READY_EN
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                        state   <= S_T1;
                    end
                end
                S_T1: state <= S_T2;
                S_T2: state <= S_T3;
                S_T3, S_TW: begin
`ifdef BUS_READY_EN
                    // READY is sampled at the close of T3 and of every TW
                    if (READY) begin
                        if (!write_q) begin
                            rdata_q <= DATA;
                        end
                        state <= S_T4;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        // Timeout: finish the cycle without touching rdata
                        err_q <= 1'b1;
                        state <= S_T4;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        state    <= S_TW;
                    end
`else
                    if (!write_q) begin
                        rdata_q <= DATA;
                    end
                    state <= S_T4;
`endif
                end
                S_T4:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus pins and host-side status decoded from the current phase
    always_comb begin
        strobe      = (state == S_T2) || (state == S_T3) || (state == S_TW);
        data_oe     = strobe && write_q;
        cmd_ready   = (state == S_IDLE);
        ALE         = (state == S_T1);
        RD          = !(strobe && !write_q);
        WR          = !(strobe && write_q);
        rsp_valid   = (state == S_T4);
        rsp_rdata   = rdata_q;
        IOM         = iom_q;
        ADDR        = addr_q;
        dbg_state   = state;
        dbg_data_oe = data_oe;
`ifdef BUS_READY_EN
        rsp_err     = err_q && (state == S_T4);
        dbg_wait    = wait_cnt;
`else
        rsp_err     = 1'b0;
        dbg_wait    = '0;
`endif
    end

    // Shared data bus: driven only while a write strobe is active
    assign DATA = data_oe ? wdata_q : {DATA_W{1'bz}};

endmodule
